// File: rtl/riscv_pkg.sv
// Shared types, funct3 width codes and request legality check for the RISC-V load/store unit.
package riscv_pkg;

  typedef enum logic [1:0] {IDLE, MEM, RESP} lsu_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_TIMEOUT    = 2'd2,
    CAUSE_ILLEGAL    = 2'd3
  } lsu_cause_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Illegal width outranks misalignment; LWU and 8-byte accesses only exist on RV64.
  function automatic lsu_cause_t lsu_check(input logic store, input logic [2:0] funct3,
                                           input logic [2:0] addr_lo, input int unsigned xlen);
    logic illegal;
    logic misaligned;
    illegal = (funct3 == 3'b111) || (store && funct3[2]) ||
              ((xlen == 32) && ((funct3[1:0] == 2'b11) || (funct3 == LWU)));
    unique case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo[1:0];
      default: misaligned = |addr_lo;
    endcase
    if (illegal)         return CAUSE_ILLEGAL;
    else if (misaligned) return CAUSE_MISALIGNED;
    else                 return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane alignment: word-aligned address, shifted store data/strobes and extended load data.
module riscv_lsu_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic              store,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   load_data
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OB = $clog2(NB);

  logic [OB-1:0]   offset;
  logic [OB+2:0]   bit_sh;
  logic [3:0]      nbytes;
  logic [15:0]     mask16;
  logic [XLEN-1:0] shifted;

  assign offset    = addr[OB-1:0];
  assign bit_sh    = {offset, 3'b000};
  assign nbytes    = 4'd1 << funct3[1:0];
  assign mask16    = (16'd1 << nbytes) - 16'd1;
  assign mem_addr  = {addr[XLEN-1:OB], {OB{1'b0}}};
  assign mem_wdata = wdata << bit_sh;
  assign shifted   = mem_rdata >> bit_sh;

  always_comb begin
    mem_wstrb = '0;
    if (store) mem_wstrb = NB'(mask16) << offset;
  end

  // funct3[2] selects zero extension; a signed source makes the size cast sign-extend.
  always_comb begin
    load_data = shifted;
    unique case (funct3[1:0])
      2'b00:   load_data = funct3[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'b01:   load_data = funct3[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'b10:   load_data = funct3[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: one outstanding request, IDLE -> MEM -> RESP handshake with fault/timeout reporting.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_trap,
  output logic [1:0]        resp_cause,
  output logic              mem_valid,
  output logic              mem_instr,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata
);
  lsu_state_t state_q, state_d;

  logic            store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [4:0]      rd_q;
  logic [31:0]     cnt_q;

  logic [XLEN-1:0] resp_rdata_q;
  logic [4:0]      resp_rd_q;
  logic            resp_trap_q;
  lsu_cause_t      resp_cause_q;

  logic            accept, timeout;
  lsu_cause_t      req_cause;

  logic [XLEN-1:0]   a_mem_addr, a_mem_wdata, a_load_data;
  logic [XLEN/8-1:0] a_mem_wstrb;

  assign accept    = req_valid && (state_q == IDLE);
  assign req_cause = lsu_check(req_store, req_funct3, req_addr[2:0], XLEN);
  assign timeout   = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1) && !mem_ready;
  assign mem_instr = 1'b0;

  riscv_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (funct3_q),
    .store     (store_q),
    .addr      (addr_q),
    .wdata     (wdata_q),
    .mem_rdata (mem_rdata),
    .mem_addr  (a_mem_addr),
    .mem_wdata (a_mem_wdata),
    .mem_wstrb (a_mem_wstrb),
    .load_data (a_load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (req_cause == CAUSE_NONE) ? MEM : RESP;
      MEM:     if (mem_ready || timeout) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    resp_rdata = '0;
    resp_rd    = '0;
    resp_trap  = 1'b0;
    resp_cause = '0;
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      MEM: begin
        mem_valid = 1'b1;
        mem_addr  = a_mem_addr;
        mem_wdata = a_mem_wdata;
        mem_wstrb = a_mem_wstrb;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = resp_rdata_q;
        resp_rd    = resp_rd_q;
        resp_trap  = resp_trap_q;
        resp_cause = resp_cause_q;
      end
      default: ;
    endcase
  end

  // Faults are decided from the live request; memory results are captured on leaving MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_q      <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      resp_trap_q  <= 1'b0;
      resp_cause_q <= CAUSE_NONE;
    end else begin
      if (accept) begin
        store_q  <= req_store;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rd_q     <= req_rd;
        cnt_q    <= '0;
        if (req_cause != CAUSE_NONE) begin
          resp_rdata_q <= '0;
          resp_rd_q    <= req_store ? 5'd0 : req_rd;
          resp_trap_q  <= 1'b1;
          resp_cause_q <= req_cause;
        end
      end
      if (state_q == MEM) begin
        cnt_q <= cnt_q + 32'd1;
        if (mem_ready) begin
          resp_rdata_q <= store_q ? '0 : a_load_data;
          resp_rd_q    <= store_q ? 5'd0 : rd_q;
          resp_trap_q  <= 1'b0;
          resp_cause_q <= CAUSE_NONE;
        end else if (timeout) begin
          resp_rdata_q <= '0;
          resp_rd_q    <= store_q ? 5'd0 : rd_q;
          resp_trap_q  <= 1'b1;
          resp_cause_q <= CAUSE_TIMEOUT;
        end
      end
    end
  end

endmodule
